// File: rtl/cpu_run_controller.sv
// Run/halt sequencer for the single-cycle core.
// Holds the core idle for a boot window after reset, then gates the PC and
// write enables according to ECALL halt and debug halt/resume/step requests.
// Also keeps a cycle counter (cycles outside BOOT) and a retired-instruction counter.
module cpu_run_controller #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Halt,
  input  logic             DbgHaltReq,
  input  logic             DbgRunReq,
  input  logic             DbgStepReq,
  output logic             PCEn,
  output logic             WrEn,
  output logic             Halted,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstRet
);

  // A zero-length boot window would never let the counter match, so clamp to 1.
  localparam int BOOT_N = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
  localparam int BOOT_W = (BOOT_N > 1) ? $clog2(BOOT_N) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_N - 1);

  localparam logic [1:0] ST_BOOT   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;
  localparam logic [1:0] ST_HALTED = 2'b11;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [BOOT_W-1:0] boot_cnt_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic [CNT_W-1:0]  inst_ret_q;
  logic              active;

  // Counters wrap silently; no saturation or overflow flag.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] x);
    return x + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // An instruction executes (and retires) only in RUN/STEP when it is not the ECALL.
  assign active   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !Halt;
  assign PCEn     = active;
  assign WrEn     = active;
  assign Halted   = (state_q == ST_HALTED);
  assign State    = state_q;
  assign CycleCnt = cycle_cnt_q;
  assign InstRet  = inst_ret_q;

  // Next-state selection; debug requests only matter in RUN (halt) and HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // ECALL halts without retiring; debug halt retires the current instruction first.
        if (Halt || DbgHaltReq) state_d = ST_HALTED;
      end
      ST_STEP: begin
        state_d = ST_HALTED;
      end
      default: begin
        // ECALL halt is terminal; halt beats step, step beats run.
        if (Halt || DbgHaltReq) state_d = ST_HALTED;
        else if (DbgStepReq)    state_d = ST_STEP;
        else if (DbgRunReq)     state_d = ST_RUN;
      end
    endcase
  end

  // State, boot window counter and the two performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      inst_ret_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_BOOT && boot_cnt_q != BOOT_LAST)
        boot_cnt_q <= boot_cnt_q + {{(BOOT_W-1){1'b0}}, 1'b1};
      if (state_q != ST_BOOT)
        cycle_cnt_q <= wrap_inc(cycle_cnt_q);
      if (active)
        inst_ret_q <= wrap_inc(inst_ret_q);
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a per-cycle reference model pushes the expected
// outputs into a scoreboard queue as each cycle's stimulus is driven; the entry
// is popped and compared when the DUT outputs settle on the falling edge.
module tb_cpu_run_controller;

  localparam int BOOT = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset, Halt, DbgHaltReq, DbgRunReq, DbgStepReq;
  logic          PCEn, WrEn, Halted;
  logic [1:0]    State;
  logic [CW-1:0] CycleCnt, InstRet;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0]    st;
    logic          pc;
    logic          hl;
    logic [CW-1:0] cc;
    logic [CW-1:0] ir;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_st = 0;
  int m_b  = 0;
  int m_cc = 0;
  int m_ir = 0;

  cpu_run_controller #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .Halt       (Halt),
    .DbgHaltReq (DbgHaltReq),
    .DbgRunReq  (DbgRunReq),
    .DbgStepReq (DbgStepReq),
    .PCEn       (PCEn),
    .WrEn       (WrEn),
    .Halted     (Halted),
    .State      (State),
    .CycleCnt   (CycleCnt),
    .InstRet    (InstRet)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @cycle %0d: got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // One clock cycle: drive inputs, push model expectation, compare at negedge, advance model.
  task automatic step_cycle(input logic r, input logic h, input logic dh,
                            input logic dr, input logic ds);
    exp_t e;
    exp_t o;
    logic run_now;
    reset = r; Halt = h; DbgHaltReq = dh; DbgRunReq = dr; DbgStepReq = ds;
    run_now = (m_st == 1 || m_st == 2) && !h;
    e.st = 2'(m_st);
    e.pc = run_now;
    e.hl = (m_st == 3);
    e.cc = CW'(m_cc);
    e.ir = CW'(m_ir);
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    check_val("state",  32'(State),    32'(o.st));
    check_val("pcen",   32'(PCEn),     32'(o.pc));
    check_val("wren",   32'(WrEn),     32'(o.pc));
    check_val("halted", 32'(Halted),   32'(o.hl));
    check_val("cyccnt", 32'(CycleCnt), 32'(o.cc));
    check_val("instret",32'(InstRet),  32'(o.ir));
    @(posedge clk);
    if (r) begin
      m_st = 0; m_b = 0; m_cc = 0; m_ir = 0;
    end else begin
      if (m_st != 0) m_cc = (m_cc + 1) % (1 << CW);
      if (run_now)   m_ir = (m_ir + 1) % (1 << CW);
      case (m_st)
        0: if (m_b == BOOT - 1) m_st = 1; else m_b = m_b + 1;
        1: if (h || dh) m_st = 3;
        2: m_st = 3;
        default: if (h || dh) m_st = 3; else if (ds) m_st = 2; else if (dr) m_st = 1;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset, then walk through the boot window (with debug requests that must be ignored).
  task automatic reset_and_boot;
    step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < BOOT; i++) step_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    int zero_seen;
    reset = 1'b1; Halt = 1'b0; DbgHaltReq = 1'b0; DbgRunReq = 1'b0; DbgStepReq = 1'b0;
    @(posedge clk); #1;
    cyc = 1;

    // 1: boot window
    step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t1_rst_pcen", 32'(PCEn), 32'd0);
    check_val("t1_rst_state", 32'(State), 32'd0);
    for (int i = 0; i < BOOT; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < BOOT - 1) check_val("t1_boot_pcen", 32'(PCEn), 32'd0);
    end
    check_val("t1_run_pcen", 32'(PCEn), 32'd1);
    check_val("t1_run_state", 32'(State), 32'd1);
    check_val("t1_run_cc", 32'(CycleCnt), 32'd0);

    // 2: run 10, ECALL halt, resume/step requests ignored while ECALL is held
    for (int i = 0; i < 10; i++) step_cycle(1'b0, 1'b0, 1'b0, (i == 3), (i == 5));
    step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t2_halted", 32'(Halted), 32'd1);
    check_val("t2_instret", 32'(InstRet), 32'd10);
    for (int i = 0; i < 5; i++) step_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("t2_still_halted", 32'(Halted), 32'd1);
    check_val("t2_instret_kept", 32'(InstRet), 32'd10);

    // 3: debug halt retires the current instruction
    reset_and_boot();
    idle(3);
    check_val("t3_instret3", 32'(InstRet), 32'd3);
    step_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("t3_halted", 32'(Halted), 32'd1);
    check_val("t3_instret4", 32'(InstRet), 32'd4);

    // 4: single step, then held step
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t4_step_state", 32'(State), 32'd2);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t4_back_halted", 32'(State), 32'd3);
    check_val("t4_instret5", 32'(InstRet), 32'd5);
    for (int i = 0; i < 6; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t4_instret8", 32'(InstRet), 32'd8);

    // ECALL presented during STEP: no retire, ends halted (terminal)
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t4_ecall_step_ir", 32'(InstRet), 32'd8);

    // 5: halt beats run; run alone resumes (ECALL released so resume is legal)
    step_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("t5_stay_halted", 32'(State), 32'd3);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t5_run_state", 32'(State), 32'd1);
    check_val("t5_run_pcen", 32'(PCEn), 32'd1);

    // 6: InstRet wrap, then reset mid-RUN with CycleCnt=9
    zero_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (InstRet == '0) zero_seen++;
    end
    check_val("t6_wrap_seen", 32'(zero_seen), 32'd1);
    reset_and_boot();
    idle(9);
    check_val("t6_cc9", 32'(CycleCnt), 32'd9);
    step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t6_rst_state", 32'(State), 32'd0);
    check_val("t6_rst_cc", 32'(CycleCnt), 32'd0);
    check_val("t6_rst_ir", 32'(InstRet), 32'd0);
    check_val("t6_rst_pcen", 32'(PCEn), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      step_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
